// File: rtl/stream_packer.sv
// ============================================================================
// Module   : stream_packer
// Purpose  : Packs RATIO narrow input beats into one wide output word per
//            transfer. Packets (delimited by in_last) may end on any lane;
//            the final word of a packet is zero-padded and flagged via
//            out_keep/out_last, and carries the packet word count.
// Ports    : clk, rst                - clock, async active-high reset
//            in_valid/in_ready       - input beat handshake
//            in_data[IN_WIDTH]       - input beat payload
//            in_last                 - final beat of packet
//            out_valid/out_ready     - output word handshake
//            out_data[OUT_WIDTH]     - packed word, first beat in low lane
//            out_keep[RATIO]         - lane occupancy of out_data
//            out_last                - final word of packet
//            out_word_count[CNT_W]   - words in packet (meaningful with out_last)
//            overflow                - sticky: a packet exceeded MAX_WORDS
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module stream_packer #(
  parameter int  IN_WIDTH  = 8,
  parameter int  RATIO     = 4,
  parameter int  MAX_WORDS = 256,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [RATIO-1:0]     out_keep,
  output logic                 out_last,
  output logic [CNT_W-1:0]     out_word_count,
  output logic                 overflow
);

  localparam int                LANE_W    = $clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_WORDS);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [OUT_WIDTH-1:0]   buf_q, buf_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic [RATIO-1:0]       out_keep_q, out_keep_d;
  logic                   out_last_q, out_last_d;
  logic [CNT_W-1:0]       out_count_q, out_count_d;
  logic [CNT_W-1:0]       words_q, words_d;
  logic                   overflow_q, overflow_d;

  logic                   accept;
  logic                   complete;
  logic [OUT_WIDTH-1:0]   merged;
  logic [RATIO-1:0]       keep_new;
  logic [CNT_W-1:0]       words_next;

  assign out_valid      = (state_q == EMIT);
  assign in_ready       = !out_valid || out_ready;
  assign accept         = in_valid && in_ready;
  assign complete       = accept && ((lane_q == LAST_LANE) || in_last);

  assign out_data       = out_data_q;
  assign out_keep       = out_keep_q;
  assign out_last       = out_last_q;
  assign out_word_count = out_count_q;
  assign overflow       = overflow_q;

  // Lane buffer with the current beat dropped into its lane. The buffer is
  // cleared whenever a word completes, so lanes above lane_q are always zero.
  always_comb begin
    merged   = buf_q;
    keep_new = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (LANE_W'(i) == lane_q) begin
        merged[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end
      keep_new[i] = (LANE_W'(i) <= lane_q);
    end
  end

  // Word counter saturates; the count after saturation stays at MAX_WORDS.
  assign words_next = (words_q == CNT_MAX) ? words_q : (words_q + CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_count_d = out_count_q;
    words_d     = words_q;
    overflow_d  = overflow_q;

    if (out_valid && out_ready) begin
      state_d = ACCUM;
    end

    if (accept) begin
      if (complete) begin
        // Completion overrides the handshake return to ACCUM: no bubble.
        state_d     = EMIT;
        lane_d      = '0;
        buf_d       = '0;
        out_data_d  = merged;
        out_keep_d  = keep_new;
        out_last_d  = in_last;
        out_count_d = words_next;
        words_d     = in_last ? '0 : words_next;
        if (words_q == CNT_MAX) begin
          overflow_d = 1'b1;
        end
      end else begin
        lane_d = lane_q + LANE_W'(1);
        buf_d  = merged;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      lane_q      <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_count_q <= '0;
      words_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_count_q <= out_count_d;
      words_q     <= words_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_packer.sv
// ============================================================================
// Module   : tb_stream_packer
// Purpose  : Self-checking bench for stream_packer (IN_WIDTH=8, RATIO=4,
//            MAX_WORDS=2). A packet-level model turns accepted beats into
//            expected words; a negedge compare process checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_stream_packer;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int MW = 2;
  localparam int OW = IW * R;
  localparam int CW = $clog2(MW + 1);

  typedef struct {
    logic [OW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
    logic [CW-1:0] cnt;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [R-1:0]  out_keep;
  logic          out_last;
  logic [CW-1:0] out_word_count;
  logic          overflow;

  stream_packer #(.IN_WIDTH(IW), .RATIO(R), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .out_word_count(out_word_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int    n_pass = 0;
  int    n_total = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  word_t exp_q[$];
  word_t exp_log[$];
  logic [IW-1:0] pkt[$];
  logic  exp_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Packet-level model: the n-th accepted beat of a packet closes a word when
  // n is a multiple of RATIO or it is the last beat; that word holds the
  // trailing k beats, is word number ceil(n/RATIO) of the packet.
  function automatic void model_accept(input logic [IW-1:0] d, input logic l);
    int    n, k, w;
    word_t wd;
    pkt.push_back(d);
    n = pkt.size();
    if (l || (n % R) == 0) begin
      k = (n - 1) % R + 1;
      w = (n + R - 1) / R;
      wd.data = '0;
      for (int j = 0; j < k; j++) wd.data[j*IW +: IW] = pkt[n-k+j];
      wd.keep = R'((1 << k) - 1);
      wd.last = l;
      wd.cnt  = CW'((w > MW) ? MW : w);
      if (w > MW) exp_ovf = 1'b1;
      exp_q.push_back(wd);
      if (l) pkt.delete();
    end
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pkt.delete();
      exp_ovf = 1'b0;
    end else begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'((exp_q.size() == 0) || out_ready));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      if (out_valid && exp_q.size() != 0) begin
        check("out_data", 64'(out_data), 64'(exp_q[0].data));
        check("out_keep", 64'(out_keep), 64'(exp_q[0].keep));
        check("out_last", 64'(out_last), 64'(exp_q[0].last));
        if (exp_q[0].last) check("out_word_count", 64'(out_word_count), 64'(exp_q[0].cnt));
        if (out_ready) exp_log.push_back(exp_q.pop_front());
      end
      if (in_valid && in_ready) model_accept(in_data, in_last);
    end
  end

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Entered and left at posedge+1.
  task automatic send(input logic [IW-1:0] d, input logic l);
    int  waits = 0;
    bit  done  = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else if (++waits > 200) begin
        fail_now("accept");
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_keep", 64'(out_keep), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_word_count", 64'(out_word_count), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    exp_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Four beats, one full word.
    ready_mode = 0;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    drain();
    check("t1_words", 64'(exp_log.size()), 64'(1));
    if (exp_log.size() == 1) begin
      check("t1_data", 64'(exp_log[0].data), 64'h44332211);
      check("t1_keep", 64'(exp_log[0].keep), 64'hF);
      check("t1_last", 64'(exp_log[0].last), 64'(1));
      check("t1_cnt", 64'(exp_log[0].cnt), 64'(1));
    end

    // Six beats: full word then a two-lane partial word.
    exp_log.delete();
    for (int i = 1; i <= 6; i++) send(IW'(i), i == 6);
    drain();
    check("t2_words", 64'(exp_log.size()), 64'(2));
    if (exp_log.size() == 2) begin
      check("t2_data0", 64'(exp_log[0].data), 64'h04030201);
      check("t2_keep0", 64'(exp_log[0].keep), 64'hF);
      check("t2_last0", 64'(exp_log[0].last), 64'(0));
      check("t2_data1", 64'(exp_log[1].data), 64'h00000605);
      check("t2_keep1", 64'(exp_log[1].keep), 64'h3);
      check("t2_last1", 64'(exp_log[1].last), 64'(1));
      check("t2_cnt1", 64'(exp_log[1].cnt), 64'(2));
    end

    // Backpressure plus counter saturation: 12 beats with MAX_WORDS=2.
    exp_log.delete();
    ready_mode = 2;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(IW'(i), i == 12);
      end
      begin
        repeat (10) @(negedge clk);
        check("t3_stall_in_ready", 64'(in_ready), 64'(0));
        check("t3_stall_valid", 64'(out_valid), 64'(1));
        check("t3_stall_data", 64'(out_data), 64'h04030201);
        check("t3_stall_ovf", 64'(overflow), 64'(0));
        ready_mode = 0;
      end
    join
    drain();
    check("t3_words", 64'(exp_log.size()), 64'(3));
    if (exp_log.size() == 3) begin
      check("t3_data1", 64'(exp_log[1].data), 64'h08070605);
      check("t3_data2", 64'(exp_log[2].data), 64'h0C0B0A09);
      check("t3_last2", 64'(exp_log[2].last), 64'(1));
      check("t3_cnt2", 64'(exp_log[2].cnt), 64'(2));
    end
    check("t3_ovf", 64'(overflow), 64'(1));
    idle(5);
    check("t3_ovf_sticky", 64'(overflow), 64'(1));

    // Reset with a word held in EMIT and a beat waiting.
    apply_reset();
    ready_mode = 2;
    send(8'h10, 0); send(8'h11, 0); send(8'h12, 0); send(8'h13, 0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    idle(2);
    check("t4_emit_held", 64'(out_valid), 64'(1));
    apply_reset();
    ready_mode = 0;
    // Reset with two beats buffered.
    send(8'h55, 0); send(8'h66, 0);
    apply_reset();
    send(8'hAA, 1);
    drain();
    check("t4_words", 64'(exp_log.size()), 64'(1));
    if (exp_log.size() == 1) begin
      check("t4_data", 64'(exp_log[0].data), 64'h000000AA);
      check("t4_keep", 64'(exp_log[0].keep), 64'h1);
      check("t4_cnt", 64'(exp_log[0].cnt), 64'(1));
    end

    // Random packets, gaps, backpressure and occasional resets.
    ready_mode = 1;
    for (int p = 0; p < 150; p++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(IW'($urandom), b == len - 1);
      end
      if ($urandom_range(0, 29) == 0) apply_reset();
    end
    ready_mode = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8: input beat width in bits; SHALL be ≥1.
REQ-002 Parameter RATIO, default 4: input beats per output word; SHALL be ≥2. OUT_WIDTH = IN_WIDTH*RATIO.
REQ-003 Parameter MAX_WORDS, default 256: maximum output words per packet; counter widths SHALL be sized by ceiling-log2 of (MAX_WORDS+1).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-008 in_data  in  IN_WIDTH  input beat payload.
REQ-009 in_last  in  1  final beat of packet.
REQ-010 out_valid  out  1  output word valid.
REQ-011 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-012 out_data  out  OUT_WIDTH  packed word; first accepted beat of a word in bits [IN_WIDTH-1:0].
REQ-013 out_keep  out  RATIO  one bit per lane; 1 = lane holds a real beat.
REQ-014 out_last  out  1  final word of packet.
REQ-015 out_word_count  out  clog2(MAX_WORDS+1)  words in packet; valid only while out_valid && out_last.
REQ-016 overflow  out  1  sticky: packet exceeded MAX_WORDS.

Function
REQ-017 Two states: ACCUM (filling lane buffer), EMIT (output register holds word, out_valid=1).
REQ-018 Lane index lane_q counts 0..RATIO-1; accepted beat written to lane lane_q, lane_q increments.
REQ-019 Word completes when accepted beat has lane_q==RATIO-1 or in_last=1; completion loads output register next edge, lane_q returns to 0, state -> EMIT.
REQ-020 out_keep on completion = bits [lane_q:0] set; unfilled lanes of out_data SHALL be zero.
REQ-021 in_ready = !out_valid || out_ready (combinational); a completing beat in the same cycle as an output handshake loads the new word with no bubble.
REQ-022 EMIT -> ACCUM on output handshake when no new word completes that cycle; out_valid deasserts next edge.
REQ-023 Latency: completing beat accepted at edge N -> out_valid=1 after edge N (visible in cycle N+1).
REQ-024 out_data/out_keep/out_last/out_word_count SHALL be stable while out_valid && !out_ready.
REQ-025 Word counter increments per completed word, clears after the word carrying out_last is loaded; out_word_count = ceil(beats/RATIO) for the packet (partial final word counts 1).
REQ-026 Single-beat packet (in_last on lane 0): one word, out_keep=...0001, out_word_count=1.
REQ-027 Word counter saturates at MAX_WORDS; completing word MAX_WORDS+1 sets overflow; overflow clears only on reset.
REQ-028 in_valid=0 leaves all state unchanged; no timeout flush of partial words.
REQ-029 Non-accepted beats (in_ready=0) SHALL not alter lane buffer or counters.

Reset
REQ-030 While rst=1: out_valid=0, out_data=0, out_keep=0, out_last=0, out_word_count=0, overflow=0, lane_q=0, state=ACCUM; in_ready=1 after release.
REQ-031 Reset mid-packet or mid-EMIT SHALL discard buffered beats and pending word; no output produced for them after release.

Verification
REQ-032 IN_WIDTH=8, RATIO=4; beats 11,22,33,44 (last on 44), out_ready=1 -> one word out_data=0x44332211, keep=1111, last=1, count=1.
REQ-033 Six beats 01..06, last on 06 -> word 0x04030201 keep=1111 last=0; word 0x00000605 keep=0011 last=1 count=2.
REQ-034 Continuous in_valid, out_ready held 0 after first word -> in_ready=0, out_data stable; release out_ready -> no beat lost or duplicated, back-to-back words with no bubble.
REQ-035 MAX_WORDS=2, 12-beat packet -> overflow=1 on third word, count saturated at 2, overflow stays 1 until reset.
REQ-036 Assert rst with 2 beats buffered and one word in EMIT -> outputs zero immediately; next packet 0xAA (last) -> word 0x000000AA keep=0001 count=1.
